// File: rtl/hex_scroll_seq.sv
// rtl/hex_scroll_seq.sv - circular message store with tick/step scrolling into four digit code outputs
module hex_scroll_seq #(
  parameter int          ADDR_W     = 3,
  parameter int          CLK_DIV    = 50000000,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              run,
  input  logic              step,
  input  logic              dir,
  output logic [3:0]        hex3_code,
  output logic [3:0]        hex2_code,
  output logic [3:0]        hex1_code,
  output logic [3:0]        hex0_code,
  output logic [ADDR_W-1:0] pos,
  output logic              wrap
);

  localparam int MSG_LEN = 2 ** ADDR_W;
  // A divider of 1 still needs a one-bit counter that sits at its terminal value.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] POS_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  logic [3:0]        msg_q [MSG_LEN];
  logic [3:0]        msg_d [MSG_LEN];
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [3:0]        hex3_q, hex3_d;
  logic [3:0]        hex2_q, hex2_d;
  logic [3:0]        hex1_q, hex1_d;
  logic [3:0]        hex0_q, hex0_d;

  logic adv_tick;
  logic step_rise;
  logic adv;

  // Next-state: divider, press detect, position update, wrap flag, message write and digit fetch.
  always_comb begin
    adv_tick  = run && (cnt_q == CNT_MAX);
    step_rise = step && !step_q;
    adv       = adv_tick || (step_rise && !run);

    if (!run || adv_tick) cnt_d = '0;
    else                  cnt_d = cnt_q + CNT_W'(1);

    step_d = step;

    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (adv) begin
      if (!dir) begin
        pos_d  = pos_q + ONE;
        wrap_d = (pos_q == POS_MAX);
      end else begin
        pos_d  = pos_q - ONE;
        wrap_d = (pos_q == '0);
      end
    end

    msg_d = msg_q;
    if (wr_en) msg_d[wr_addr] = wr_data;

    // Fetch uses the registered pos/msg so outputs lag any change by one edge.
    hex3_d = msg_q[pos_q];
    hex2_d = msg_q[pos_q + ONE];
    hex1_d = msg_q[pos_q + ADDR_W'(2)];
    hex0_d = msg_q[pos_q + ADDR_W'(3)];
  end

  // State registers; reset wins over any write, press or tick in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= BLANK_CODE;
      pos_q  <= '0;
      cnt_q  <= '0;
      step_q <= 1'b1;
      wrap_q <= 1'b0;
      hex3_q <= BLANK_CODE;
      hex2_q <= BLANK_CODE;
      hex1_q <= BLANK_CODE;
      hex0_q <= BLANK_CODE;
    end else begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= msg_d[i];
      pos_q  <= pos_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      hex3_q <= hex3_d;
      hex2_q <= hex2_d;
      hex1_q <= hex1_d;
      hex0_q <= hex0_d;
    end
  end

  assign hex3_code = hex3_q;
  assign hex2_code = hex2_q;
  assign hex1_code = hex1_q;
  assign hex0_code = hex0_q;
  assign pos       = pos_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_hex_scroll_seq.sv
// tb/tb_hex_scroll_seq.sv - directed self-checking bench for hex_scroll_seq
module tb_hex_scroll_seq;

  localparam int ADDR_W  = 3;
  localparam int CLK_DIV = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic              run;
  logic              step;
  logic              dir;
  logic [3:0]        hex3_code, hex2_code, hex1_code, hex0_code;
  logic [ADDR_W-1:0] pos;
  logic              wrap;

  int total = 0;
  int bad   = 0;

  hex_scroll_seq #(
    .ADDR_W    (ADDR_W),
    .CLK_DIV   (CLK_DIV),
    .BLANK_CODE(4'hF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .run      (run),
    .step     (step),
    .dir      (dir),
    .hex3_code(hex3_code),
    .hex2_code(hex2_code),
    .hex1_code(hex1_code),
    .hex0_code(hex0_code),
    .pos      (pos),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] codes();
    return {hex3_code, hex2_code, hex1_code, hex0_code};
  endfunction

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    run = 1'b0; step = 1'b1; dir = 1'b0;

    // Reset for two edges with step held high
    cyc(2);
    reset = 1'b0;
    chk("rst_codes", codes(), 16'hFFFF);
    chk("rst_pos", 16'(pos), 16'd0);
    chk("rst_wrap", 16'(wrap), 16'd0);
    cyc(3);
    step = 1'b0;
    cyc(2);
    chk("rst_step_held", 16'(pos), 16'd0);

    // Load 1..8
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 4'(i + 1);
      cyc(1);
    end
    wr_en = 1'b0;
    cyc(1);
    chk("load_codes", codes(), 16'h1234);
    chk("load_pos", 16'(pos), 16'd0);

    // Auto-scroll left: advances on edges 4,8,12,...
    run = 1'b1; dir = 1'b0;
    cyc(3);
    chk("left_no_adv_yet", 16'(pos), 16'd0);
    cyc(1);
    chk("left_first_pos", 16'(pos), 16'd1);
    cyc(1);
    chk("left_first_codes", codes(), 16'h2345);
    cyc(16);
    chk("left_pos5", 16'(pos), 16'd5);
    chk("left_pos5_codes", codes(), 16'h6781);
    chk("left_pos5_wrap", 16'(wrap), 16'd0);
    cyc(11);
    chk("left_wrap_pos", 16'(pos), 16'd0);
    chk("left_wrap_pulse", 16'(wrap), 16'd1);
    chk("left_wrap_codes_lag", codes(), 16'h8123);
    cyc(1);
    chk("left_wrap_end", 16'(wrap), 16'd0);
    chk("left_wrap_codes", codes(), 16'h1234);

    // Scroll right from pos 0; counter keeps its count across the dir change
    dir = 1'b1;
    cyc(3);
    chk("right_pos", 16'(pos), 16'd7);
    chk("right_wrap", 16'(wrap), 16'd1);
    cyc(1);
    chk("right_wrap_end", 16'(wrap), 16'd0);
    chk("right_codes", codes(), 16'h8123);

    // Single-step three presses from pos 7, left
    run = 1'b0; dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      cyc(1);
      if (k == 0) begin
        chk("step_first_pos", 16'(pos), 16'd0);
        chk("step_first_wrap", 16'(wrap), 16'd1);
      end
      cyc(4);
      step = 1'b0;
      cyc(5);
    end
    chk("step_three_pos", 16'(pos), 16'd2);

    // Press while running adds nothing beyond tick cadence
    run = 1'b1; step = 1'b1;
    cyc(3);
    chk("run_step_ignored", 16'(pos), 16'd2);
    step = 1'b0;
    cyc(1);
    chk("run_tick_pos", 16'(pos), 16'd3);

    // Write slot 4 on the same edge pos advances to 4
    cyc(3);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'hA;
    cyc(1);
    wr_en = 1'b0;
    chk("collide_pos", 16'(pos), 16'd4);
    cyc(1);
    chk("collide_codes", codes(), 16'hA678);

    // Reset with counter at 2; next advance comes 4 edges after release
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midrst_pos", 16'(pos), 16'd0);
    chk("midrst_codes", codes(), 16'hFFFF);
    cyc(2);
    chk("midrst_no_early_adv", 16'(pos), 16'd0);
    cyc(1);
    chk("midrst_still0", 16'(pos), 16'd0);
    cyc(1);
    chk("midrst_adv", 16'(pos), 16'd1);
    chk("midrst_blank_codes", codes(), 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
